load_unit: RTL and testbench
============================

# load_unit

Memory-access stage for RISC-V integer loads, sitting directly downstream of the load-immediate decoder. It accepts one decoded load (op code, base register value, 12-bit offset, destination register), computes the effective address, and performs one word read on the data-memory request/response interface. It then aligns and sign/zero-extends the returned data and presents a single-cycle writeback to the register file. Misaligned accesses and unanswered requests are reported as faults instead of being written back.

## Interface
Parameters:
- RSP_TIMEOUT, 16: maximum cycles spent in WAIT before a timeout fault; legal range 1..255.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- issue_valid  in  1  decoded load presented.
- issue_ready  out  1  unit can accept; high only in IDLE.
- load_op  in  5  `LB/`LH/`LW/`LBU/`LHU/`LD_NOP from processor_defines.sv.
- rs1_data  in  32  base register value.
- imm  in  12  signed byte offset.
- rd  in  5  destination register.
- mem_req_valid  out  1  word read request.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  32  word-aligned address, bits [1:0] = 0.
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_data  in  32  read word, little-endian.
- wb_valid  out  1  one-cycle writeback strobe.
- wb_rd  out  5  writeback register.
- wb_data  out  32  extended load result.
- fault  out  1  one-cycle fault strobe.
- fault_cause  out  2  0 none, 1 misaligned, 2 timeout.
- fault_addr  out  32  full effective address of the faulting load.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: on issue_valid && issue_ready, register op, rd, and ea = rs1_data + sext(imm), truncated to 32 bits (wrap-around allowed).
  - `LD_NOP or any unlisted code: accepted and dropped; no request, no strobe; stay in IDLE.
  - Misaligned (`LH/`LHU with ea[0]=1, `LW with ea[1:0]≠0): go to DONE with fault_cause=1; no memory request.
  - Otherwise: go to REQ.
- REQ: drive mem_req_valid=1 and mem_addr={ea[31:2],2'b00}; both are held stable until mem_req_ready. On handshake, go to WAIT and clear the timeout counter. mem_rsp_valid is ignored in REQ.
- WAIT: on mem_rsp_valid, capture aligned data and go to DONE. If the counter reaches RSP_TIMEOUT, go to DONE with fault_cause=2.
- DONE (one cycle), then IDLE:
  - Normal completion: wb_valid=1, unless rd=0, in which case wb_valid is suppressed and the load still completes.
  - Fault: fault=1 with fault_cause and fault_addr valid; wb_valid=0.
- Alignment, using off=ea[1:0]:
  - `LB: sext(data[8*off+7:8*off]).
  - `LBU: same byte, zero-extended.
  - `LH: sext(data[16*off[1]+15:16*off[1]]).
  - `LHU: same half, zero-extended.
  - `LW: data unchanged.
- mem_rsp_valid outside WAIT is ignored, including a late response after a timeout.

## Timing
- Reset (rst_n low at a clock edge):
  - state→IDLE; all outputs 0, including issue_ready while rst_n is low.
  - issue_ready=1 on the first cycle after rst_n goes high.
  - Reset mid-transaction abandons the load: mem_req_valid drops next cycle and no strobe is produced.
- Minimum latency, accept at cycle N:
  - N+1: mem_req_valid.
  - N+1: mem_req_ready may be high in this cycle.
  - N+2: response.
  - N+3: wb_valid.
- Misaligned: fault at N+1.
- Timeout: fault RSP_TIMEOUT+1 cycles after the request handshake.
- wb_*, fault_* are registered; they are valid only during their strobe cycle and hold their last value otherwise.
- Throughput: one load per 4 cycles minimum; issue_ready returns on the cycle after DONE.
- issue_ready is a function of state only; it has no combinational path from issue_valid.

## Structure
- Add to processor_defines.sv:
  - state encoding for IDLE/REQ/WAIT/DONE.
  - fault-cause codes FLT_NONE/FLT_MISALIGN/FLT_TIMEOUT.
- Load op codes come from the existing defines.
- One combinational sub-module, load_align: (op, off, word) → 32-bit result. It is reused later by the store path's read-modify-write.
- Timeout counter: 8 bits, saturating.

## Test plan
- `LW, rs1=0x1000, imm=0x004, memory returns 0xDEADBEEF one cycle after request → mem_addr=0x1004, wb_data=0xDEADBEEF at accept+3.
- `LB/`LBU, rs1=0x2003, imm=0, data 0x80FF7F01 → off=3: LB wb_data=0xFFFFFF80, LBU 0x00000080; `LH at 0x2002 → 0xFFFF80FF.
- `LH at ea=0x1001 and `LW at 0x1002 → fault=1, fault_cause=1, fault_addr as computed, mem_req_valid never asserted, wb_valid=0.
- rs1=0x00000002, imm=0xFFE (−2) → ea=0x0; rs1=0xFFFFFFFC, imm=0x008 → ea=0x4 (wrap); mem_req_ready held low 5 cycles → request and address stable throughout.
- No response for RSP_TIMEOUT=16 cycles → fault_cause=2; a late mem_rsp_valid is then ignored; rd=0 load → no wb_valid; `LD_NOP → no activity, issue_ready high next cycle.
- rst_n low during WAIT → outputs 0 next cycle, no strobe; subsequent `LW completes normally.

Source files
------------

// File: rtl/load_unit_pkg.sv
// ----------------------------------------------------------------------------
// load_unit_pkg
// Shared definitions for the integer load path: load op codes, FSM state
// encoding, fault-cause codes and small decode helpers used by load_unit and
// load_align.
// ----------------------------------------------------------------------------
package load_unit_pkg;

   // Load op codes as produced by the load-immediate decoder.
   localparam logic [4:0] LD_NOP = 5'd0;
   localparam logic [4:0] LB     = 5'd1;
   localparam logic [4:0] LH     = 5'd2;
   localparam logic [4:0] LW     = 5'd3;
   localparam logic [4:0] LBU    = 5'd4;
   localparam logic [4:0] LHU    = 5'd5;

   // Load-unit FSM states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Fault-cause codes reported on fault_cause.
   localparam logic [1:0] FLT_NONE     = 2'd0;
   localparam logic [1:0] FLT_MISALIGN = 2'd1;
   localparam logic [1:0] FLT_TIMEOUT  = 2'd2;

   // True for op codes that perform a memory read; LD_NOP and unknown codes
   // are dropped.
   function automatic logic is_load_op(input logic [4:0] op);
      logic res;
      case (op)
         LB, LH, LW, LBU, LHU: res = 1'b1;
         default:              res = 1'b0;
      endcase
      return res;
   endfunction

   // Halfwords need an even address, words need a 4-byte aligned address.
   function automatic logic is_misaligned(input logic [4:0] op, input logic [1:0] off);
      logic res;
      case (op)
         LH, LHU: res = off[0];
         LW:      res = (off != 2'b00);
         default: res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/load_unit_align.sv
// ----------------------------------------------------------------------------
// load_align
// Purely combinational extraction of the addressed byte/halfword from a
// little-endian 32-bit memory word, followed by sign or zero extension.
// Ports:
//   op     - load op code (LB/LH/LW/LBU/LHU); other codes yield zero
//   off    - byte offset within the word (effective address bits [1:0])
//   word   - word returned by memory
//   result - aligned, extended load value
// ----------------------------------------------------------------------------
module load_align
   import load_unit_pkg::*;
(
   input  logic [4:0]  op,
   input  logic [1:0]  off,
   input  logic [31:0] word,
   output logic [31:0] result
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Select the addressed byte/halfword and extend it according to op.
   always_comb begin
      case (off)
         2'd0:    byte_s = word[7:0];
         2'd1:    byte_s = word[15:8];
         2'd2:    byte_s = word[23:16];
         2'd3:    byte_s = word[31:24];
         default: byte_s = word[7:0];
      endcase

      if (off[1]) begin
         half_s = word[31:16];
      end else begin
         half_s = word[15:0];
      end

      case (op)
         LB:      result = {{24{byte_s[7]}}, byte_s};
         LBU:     result = {24'h000000, byte_s};
         LH:      result = {{16{half_s[15]}}, half_s};
         LHU:     result = {16'h0000, half_s};
         LW:      result = word;
         default: result = 32'h00000000;
      endcase
   end

endmodule

// File: rtl/load_unit.sv
// ----------------------------------------------------------------------------
// load_unit
// Memory-access stage for RISC-V integer loads. Accepts one decoded load,
// computes ea = rs1 + sext(imm), issues one word read, aligns/extends the
// returned data and presents a one-cycle writeback. Misaligned loads and
// responses that never arrive are reported as one-cycle faults instead.
// Ports:
//   clk, rst_n                   - clock, synchronous active-low reset
//   issue_valid/issue_ready      - load issue handshake (ready only in IDLE)
//   load_op, rs1_data, imm, rd   - decoded load
//   mem_req_valid/ready, mem_addr- word read request (address word-aligned)
//   mem_rsp_valid, mem_rsp_data  - read response
//   wb_valid, wb_rd, wb_data     - registered writeback strobe and payload
//   fault, fault_cause, fault_addr - registered fault strobe and payload
// ----------------------------------------------------------------------------
module load_unit
   import load_unit_pkg::*;
#(
   parameter int unsigned RSP_TIMEOUT = 16
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        issue_valid,
   output logic        issue_ready,
   input  logic [4:0]  load_op,
   input  logic [31:0] rs1_data,
   input  logic [11:0] imm,
   input  logic [4:0]  rd,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        fault,
   output logic [1:0]  fault_cause,
   output logic [31:0] fault_addr
);

   localparam logic [7:0] TIMEOUT_LIM = 8'(RSP_TIMEOUT);

   state_e      state_q, state_d;
   logic [4:0]  op_q, op_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] ea_q, ea_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        issue_ready_q, issue_ready_d;
   logic        mem_req_valid_q, mem_req_valid_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic        wb_valid_q, wb_valid_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        fault_q, fault_d;
   logic [1:0]  fault_cause_q, fault_cause_d;
   logic [31:0] fault_addr_q, fault_addr_d;

   logic [31:0] ea_s;
   logic [7:0]  cnt_inc_s;
   logic [31:0] align_s;

   // Alignment uses the registered op and address so it sees the accepted load.
   load_align u_align (
      .op     (op_q),
      .off    (ea_q[1:0]),
      .word   (mem_rsp_data),
      .result (align_s)
   );

   // Next-state and next-output computation. Strobes are set on the
   // transition into DONE so that they appear registered during DONE.
   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      rd_d          = rd_q;
      ea_d          = ea_q;
      cnt_d         = cnt_q;
      mem_addr_d    = mem_addr_q;
      wb_valid_d    = 1'b0;
      wb_rd_d       = wb_rd_q;
      wb_data_d     = wb_data_q;
      fault_d       = 1'b0;
      fault_cause_d = fault_cause_q;
      fault_addr_d  = fault_addr_q;

      // Effective address wraps modulo 2^32.
      ea_s = rs1_data + {{20{imm[11]}}, imm};
      // Saturating increment keeps the 8-bit counter from wrapping.
      if (cnt_q == 8'hFF) begin
         cnt_inc_s = 8'hFF;
      end else begin
         cnt_inc_s = cnt_q + 8'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (issue_valid && issue_ready_q) begin
               op_d = load_op;
               rd_d = rd;
               ea_d = ea_s;
               if (!is_load_op(load_op)) begin
                  state_d = ST_IDLE;
               end else if (is_misaligned(load_op, ea_s[1:0])) begin
                  state_d       = ST_DONE;
                  fault_d       = 1'b1;
                  fault_cause_d = FLT_MISALIGN;
                  fault_addr_d  = ea_s;
               end else begin
                  state_d    = ST_REQ;
                  mem_addr_d = {ea_s[31:2], 2'b00};
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (mem_req_ready) begin
               state_d = ST_WAIT;
               cnt_d   = 8'd0;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_WAIT: begin
            // A response in the last waiting cycle still wins over timeout.
            if (mem_rsp_valid) begin
               state_d    = ST_DONE;
               wb_valid_d = (rd_q != 5'd0);
               wb_rd_d    = rd_q;
               wb_data_d  = align_s;
            end else begin
               cnt_d = cnt_inc_s;
               if (cnt_inc_s >= TIMEOUT_LIM) begin
                  state_d       = ST_DONE;
                  fault_d       = 1'b1;
                  fault_cause_d = FLT_TIMEOUT;
                  fault_addr_d  = ea_q;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Handshake outputs depend on the next state only, never on issue_valid.
      issue_ready_d   = (state_d == ST_IDLE);
      mem_req_valid_d = (state_d == ST_REQ);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         op_q            <= LD_NOP;
         rd_q            <= 5'd0;
         ea_q            <= 32'h00000000;
         cnt_q           <= 8'd0;
         issue_ready_q   <= 1'b0;
         mem_req_valid_q <= 1'b0;
         mem_addr_q      <= 32'h00000000;
         wb_valid_q      <= 1'b0;
         wb_rd_q         <= 5'd0;
         wb_data_q       <= 32'h00000000;
         fault_q         <= 1'b0;
         fault_cause_q   <= FLT_NONE;
         fault_addr_q    <= 32'h00000000;
      end else begin
         state_q         <= state_d;
         op_q            <= op_d;
         rd_q            <= rd_d;
         ea_q            <= ea_d;
         cnt_q           <= cnt_d;
         issue_ready_q   <= issue_ready_d;
         mem_req_valid_q <= mem_req_valid_d;
         mem_addr_q      <= mem_addr_d;
         wb_valid_q      <= wb_valid_d;
         wb_rd_q         <= wb_rd_d;
         wb_data_q       <= wb_data_d;
         fault_q         <= fault_d;
         fault_cause_q   <= fault_cause_d;
         fault_addr_q    <= fault_addr_d;
      end
   end

   assign issue_ready   = issue_ready_q;
   assign mem_req_valid = mem_req_valid_q;
   assign mem_addr      = mem_addr_q;
   assign wb_valid      = wb_valid_q;
   assign wb_rd         = wb_rd_q;
   assign wb_data       = wb_data_q;
   assign fault         = fault_q;
   assign fault_cause   = fault_cause_q;
   assign fault_addr    = fault_addr_q;

endmodule

// File: tb/tb_load_unit.sv
// ----------------------------------------------------------------------------
// tb_load_unit
// Directed, table-driven bench for load_unit. Each table entry is one load
// with its memory behaviour (request stall, response delay) and the expected
// address, writeback data or fault. Outputs are sampled on the falling edge;
// inputs are driven right after sampling.
// ----------------------------------------------------------------------------
module tb_load_unit;
   import load_unit_pkg::*;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_valid;
   logic        issue_ready;
   logic [4:0]  load_op;
   logic [31:0] rs1_data;
   logic [11:0] imm;
   logic [4:0]  rd;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        fault;
   logic [1:0]  fault_cause;
   logic [31:0] fault_addr;

   int checks   = 0;
   int failures = 0;

   load_unit #(.RSP_TIMEOUT(TO)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .issue_valid   (issue_valid),
      .issue_ready   (issue_ready),
      .load_op       (load_op),
      .rs1_data      (rs1_data),
      .imm           (imm),
      .rd            (rd),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_addr      (mem_addr),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .wb_valid      (wb_valid),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
      .fault         (fault),
      .fault_cause   (fault_cause),
      .fault_addr    (fault_addr)
   );

   always #5 clk = ~clk;

   // kind: 0 normal completion, 1 misaligned fault, 2 timeout fault, 3 dropped
   typedef struct {
      logic [4:0]  op;
      logic [31:0] rs1;
      logic [11:0] imm;
      logic [4:0]  rd;
      int          rdly;
      int          sdly;
      logic [31:0] word;
      int          kind;
      bit          late;
      logic [31:0] ea;
      logic [31:0] exp_data;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs[NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      issue_valid   = 1'b0;
      load_op       = LD_NOP;
      rs1_data      = 32'h0;
      imm           = 12'h0;
      rd            = 5'd0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'h0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int done_c;
      bit exp_req, exp_wb, exp_flt;
      case (v.kind)
         0:       done_c = 3 + v.rdly + v.sdly;
         2:       done_c = 2 + v.rdly + TO;
         default: done_c = 1;
      endcase
      chk($sformatf("v%0d ready_before", idx), {31'd0, issue_ready}, 32'd1);
      issue_valid = 1'b1;
      load_op     = v.op;
      rs1_data    = v.rs1;
      imm         = v.imm;
      rd          = v.rd;
      next_cycle();
      idle_inputs();
      for (int c = 1; c <= done_c; c++) begin
         exp_req = (v.kind == 0 || v.kind == 2) && (c <= 1 + v.rdly);
         exp_wb  = (v.kind == 0) && (v.rd != 5'd0) && (c == done_c);
         exp_flt = (v.kind == 1 || v.kind == 2) && (c == done_c);
         chk($sformatf("v%0d c%0d mem_req_valid", idx, c), {31'd0, mem_req_valid}, {31'd0, exp_req});
         if (exp_req) begin
            chk($sformatf("v%0d c%0d mem_addr", idx, c), mem_addr, {v.ea[31:2], 2'b00});
         end
         chk($sformatf("v%0d c%0d wb_valid", idx, c), {31'd0, wb_valid}, {31'd0, exp_wb});
         chk($sformatf("v%0d c%0d fault", idx, c), {31'd0, fault}, {31'd0, exp_flt});
         chk($sformatf("v%0d c%0d issue_ready", idx, c), {31'd0, issue_ready}, {31'd0, (v.kind == 3)});
         if (exp_wb) begin
            chk($sformatf("v%0d wb_rd", idx), {27'd0, wb_rd}, {27'd0, v.rd});
            chk($sformatf("v%0d wb_data", idx), wb_data, v.exp_data);
         end
         if (exp_flt) begin
            chk($sformatf("v%0d fault_cause", idx), {30'd0, fault_cause},
                (v.kind == 1) ? 32'd1 : 32'd2);
            chk($sformatf("v%0d fault_addr", idx), fault_addr, v.ea);
         end
         // Drive memory side for this cycle; junk responses while the
         // request is stalled must be ignored.
         if (v.kind == 0 || v.kind == 2) begin
            mem_req_ready = (c == 1 + v.rdly);
            if (c < 1 + v.rdly) begin
               mem_rsp_valid = 1'b1;
               mem_rsp_data  = ~v.word;
            end else if (v.kind == 0 && c == 2 + v.rdly + v.sdly) begin
               mem_rsp_valid = 1'b1;
               mem_rsp_data  = v.word;
            end else begin
               mem_rsp_valid = 1'b0;
               mem_rsp_data  = 32'h0;
            end
         end
         next_cycle();
         idle_inputs();
      end
      chk($sformatf("v%0d ready_after", idx), {31'd0, issue_ready}, 32'd1);
      chk($sformatf("v%0d wb_after", idx), {31'd0, wb_valid}, 32'd0);
      chk($sformatf("v%0d fault_after", idx), {31'd0, fault}, 32'd0);
      chk($sformatf("v%0d req_after", idx), {31'd0, mem_req_valid}, 32'd0);
      if (v.late) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = v.word;
         next_cycle();
         idle_inputs();
         chk($sformatf("v%0d late_wb", idx), {31'd0, wb_valid}, 32'd0);
         chk($sformatf("v%0d late_fault", idx), {31'd0, fault}, 32'd0);
         chk($sformatf("v%0d late_ready", idx), {31'd0, issue_ready}, 32'd1);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " issue_ready"}, {31'd0, issue_ready}, 32'd0);
      chk({tag, " mem_req_valid"}, {31'd0, mem_req_valid}, 32'd0);
      chk({tag, " mem_addr"}, mem_addr, 32'd0);
      chk({tag, " wb_valid"}, {31'd0, wb_valid}, 32'd0);
      chk({tag, " wb_data"}, wb_data, 32'd0);
      chk({tag, " fault"}, {31'd0, fault}, 32'd0);
      chk({tag, " fault_cause"}, {30'd0, fault_cause}, 32'd0);
      chk({tag, " fault_addr"}, fault_addr, 32'd0);
   endtask

   initial begin
      //            op      rs1           imm      rd  rdly sdly word          kind late ea            exp_data
      vecs[0]  = '{LW,     32'h00001000, 12'h004, 5'd5,  0, 0, 32'hDEADBEEF, 0, 1'b0, 32'h00001004, 32'hDEADBEEF};
      vecs[1]  = '{LB,     32'h00002003, 12'h000, 5'd6,  0, 0, 32'h80FF7F01, 0, 1'b0, 32'h00002003, 32'hFFFFFF80};
      vecs[2]  = '{LBU,    32'h00002003, 12'h000, 5'd7,  0, 0, 32'h80FF7F01, 0, 1'b0, 32'h00002003, 32'h00000080};
      vecs[3]  = '{LH,     32'h00002002, 12'h000, 5'd8,  0, 2, 32'h80FF7F01, 0, 1'b0, 32'h00002002, 32'hFFFF80FF};
      vecs[4]  = '{LHU,    32'h00002002, 12'h000, 5'd9,  0, 0, 32'h80FF7F01, 0, 1'b0, 32'h00002002, 32'h000080FF};
      vecs[5]  = '{LB,     32'h00002001, 12'h000, 5'd10, 1, 0, 32'h80FF7F01, 0, 1'b0, 32'h00002001, 32'h0000007F};
      vecs[6]  = '{LBU,    32'h00002002, 12'h000, 5'd11, 0, 1, 32'h80FF7F01, 0, 1'b0, 32'h00002002, 32'h000000FF};
      vecs[7]  = '{LH,     32'h00002000, 12'h000, 5'd12, 0, 0, 32'h80FF7F01, 0, 1'b0, 32'h00002000, 32'h00007F01};
      vecs[8]  = '{LH,     32'h00001001, 12'h000, 5'd13, 0, 0, 32'h0,        1, 1'b0, 32'h00001001, 32'h0};
      vecs[9]  = '{LW,     32'h00001000, 12'h002, 5'd13, 0, 0, 32'h0,        1, 1'b0, 32'h00001002, 32'h0};
      vecs[10] = '{LHU,    32'h000010FF, 12'h000, 5'd13, 0, 0, 32'h0,        1, 1'b0, 32'h000010FF, 32'h0};
      vecs[11] = '{LW,     32'h00000002, 12'hFFE, 5'd14, 0, 0, 32'h12345678, 0, 1'b0, 32'h00000000, 32'h12345678};
      vecs[12] = '{LW,     32'hFFFFFFFC, 12'h008, 5'd15, 5, 0, 32'hCAFEF00D, 0, 1'b0, 32'h00000004, 32'hCAFEF00D};
      vecs[13] = '{LW,     32'h00003000, 12'h010, 5'd3,  1, 0, 32'hA5A5A5A5, 2, 1'b1, 32'h00003010, 32'h0};
      vecs[14] = '{LW,     32'h00000100, 12'h000, 5'd0,  0, 0, 32'h55AA55AA, 0, 1'b0, 32'h00000100, 32'h0};
      vecs[15] = '{LD_NOP, 32'h00001234, 12'h000, 5'd4,  0, 0, 32'h0,        3, 1'b0, 32'h00001234, 32'h0};
      vecs[16] = '{5'd31,  32'h00001000, 12'h000, 5'd4,  0, 0, 32'h0,        3, 1'b0, 32'h00001000, 32'h0};
      vecs[17] = '{LB,     32'h00002010, 12'hFFD, 5'd16, 0, 1, 32'h0000C300, 0, 1'b0, 32'h0000200D, 32'hFFFFFFC3};

      idle_inputs();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      next_cycle();
      chk("reset_release issue_ready", {31'd0, issue_ready}, 32'd1);

      for (int i = 0; i < NV; i++) begin
         run_vec(i, vecs[i]);
      end

      // Reset while waiting for a response abandons the load.
      issue_valid = 1'b1;
      load_op     = LW;
      rs1_data    = 32'h00000040;
      rd          = 5'd7;
      next_cycle();
      idle_inputs();
      chk("rst_seq req", {31'd0, mem_req_valid}, 32'd1);
      mem_req_ready = 1'b1;
      next_cycle();
      idle_inputs();
      rst_n = 1'b0;
      next_cycle();
      chk_all_zero("rst_wait");
      rst_n = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'h11111111;
      next_cycle();
      idle_inputs();
      chk("rst_seq ready", {31'd0, issue_ready}, 32'd1);
      chk("rst_seq wb", {31'd0, wb_valid}, 32'd0);
      chk("rst_seq fault", {31'd0, fault}, 32'd0);
      run_vec(100, vecs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time bound so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
